// File: rtl/uart_rgb_pkg.sv
// Shared types and constants for the UART RGB command stage.
package uart_rgb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_HEX,
        ST_SEND,
        ST_ECHO
    } state_t;

    localparam logic [7:0]  CH_CR      = 8'h0D;
    localparam logic [7:0]  CH_LF      = 8'h0A;
    localparam logic [7:0]  CH_HASH    = 8'h23;
    localparam logic [7:0]  CH_0       = 8'h30;
    localparam logic [7:0]  CH_7       = 8'h37;
    localparam logic [31:0] UART_EMPTY = 32'hFFFF_FFFF;

    // Returns {valid, nibble}; accepts 0-9, A-F, a-f.
    function automatic logic [4:0] hex_nibble(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return {1'b1, c[3:0]};
        if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            return {1'b1, c[3:0] + 4'd9};
        return 5'd0;
    endfunction

endpackage

// File: rtl/rgb_pwm.sv
// Free-running PWM counter with one registered comparator per colour channel.
module rgb_pwm #(
    parameter int PWM_BITS = 8
) (
    input  logic                  hw_clk,
    input  logic                  reset,
    input  logic [3*PWM_BITS-1:0] duty,
    output logic [2:0]            pwm
);

    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge hw_clk) begin
        if (reset) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic pwm_q;
        always_ff @(posedge hw_clk) begin
            if (reset) pwm_q <= 1'b0;
            else       pwm_q <= (pwm_cnt < duty[i*PWM_BITS +: PWM_BITS]);
        end
        assign pwm[i] = pwm_q;
    end

endmodule

// File: rtl/uart_rgb_cmd.sv
// Parses colour commands from the simpleuart data register and drives RGB PWM.
// Define UART_RGB_ECHO_EN to echo every byte read before its reply.
module uart_rgb_cmd
    import uart_rgb_pkg::*;
#(
    parameter int         PWM_BITS       = 8,
    parameter int         TIMEOUT_CYCLES = 120000,
    parameter logic [7:0] ACK_CHAR       = 8'h4B,
    parameter logic [7:0] NAK_CHAR       = 8'h3F
) (
    input  logic        hw_clk,
    input  logic        reset,
    output logic        reg_dat_re,
    input  logic [31:0] reg_dat_do,
    output logic        reg_dat_we,
    output logic [31:0] reg_dat_di,
    input  logic        reg_dat_wait,
    output logic        rgb_red,
    output logic        rgb_green,
    output logic        rgb_blue,
    output logic        cmd_err
);

`ifdef UART_RGB_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t                     state;
    logic [7:0]                 rx_byte;
    logic                       in_hex;
    logic [2:0]                 hex_idx;
    logic [19:0]                hex_sr;   // 5 digits held; the 6th completes sr_nxt
    logic [TMO_W-1:0]           tmo_cnt;
    logic [2:0][PWM_BITS-1:0]   duty;     // [0]=red [1]=green [2]=blue
    logic [2:0][PWM_BITS-1:0]   ack_duty;
    logic [2:0]                 pwm;

    logic        byte_rdy, nib_ok, is_digit, is_hash, is_crlf;
    logic [3:0]  nib;
    logic [23:0] sr_nxt;
    logic        rep_go, rep_ack;

    // Hex bytes are left-aligned onto the duty range.
    function automatic logic [PWM_BITS-1:0] to_duty(input logic [7:0] b);
        logic [31:0] w;
        w = {b, 24'b0} >> (32 - PWM_BITS);
        return w[PWM_BITS-1:0];
    endfunction

    // The read strobe empties the buffer only at the next edge, so skip that cycle.
    assign byte_rdy     = !reg_dat_do[8] && (reg_dat_do != UART_EMPTY) && !reg_dat_re;
    assign {nib_ok, nib} = hex_nibble(rx_byte);
    assign sr_nxt       = {hex_sr, nib};
    assign is_digit     = (rx_byte >= CH_0) && (rx_byte <= CH_7);
    assign is_hash      = (rx_byte == CH_HASH);
    assign is_crlf      = (rx_byte == CH_CR) || (rx_byte == CH_LF);

    always_comb begin
        ack_duty = '0;
        if (in_hex) begin
            ack_duty[0] = to_duty(sr_nxt[23:16]);
            ack_duty[1] = to_duty(sr_nxt[15:8]);
            ack_duty[2] = to_duty(sr_nxt[7:0]);
        end else begin
            for (int i = 0; i < 3; i++)
                ack_duty[i] = {PWM_BITS{rx_byte[i]}};
        end
    end

    always_comb begin
        rep_go  = 1'b0;
        rep_ack = 1'b0;
        case (state)
            ST_HEX: rep_go = !byte_rdy && (tmo_cnt == TMO_LAST);
            ST_DECODE: begin
                if (in_hex) begin
                    rep_go  = !nib_ok || (hex_idx == 3'd5);
                    rep_ack = nib_ok;
                end else begin
                    rep_go  = !is_hash && !is_crlf;
                    rep_ack = is_digit;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge hw_clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            reg_dat_re <= 1'b0;
            reg_dat_we <= 1'b0;
            reg_dat_di <= '0;
            cmd_err    <= 1'b0;
            rx_byte    <= '0;
            in_hex     <= 1'b0;
            hex_idx    <= '0;
            hex_sr     <= '0;
            tmo_cnt    <= '0;
            duty       <= '0;
        end else begin
            reg_dat_re <= 1'b0;
            case (state)
                ST_IDLE, ST_HEX: begin
                    if (byte_rdy) begin
                        rx_byte    <= reg_dat_do[7:0];
                        reg_dat_re <= 1'b1;
                        if (ECHO) begin
                            reg_dat_di <= {24'b0, reg_dat_do[7:0]};
                            reg_dat_we <= 1'b1;
                            state      <= ST_ECHO;
                        end else begin
                            state <= ST_DECODE;
                        end
                    end else if (state == ST_HEX) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_DECODE: begin
                    if (in_hex) begin
                        hex_sr  <= sr_nxt[19:0];
                        hex_idx <= hex_idx + 3'd1;
                        tmo_cnt <= '0;
                        state   <= ST_HEX;
                    end else if (is_hash) begin
                        in_hex  <= 1'b1;
                        hex_idx <= '0;
                        hex_sr  <= '0;
                        tmo_cnt <= '0;
                        state   <= ST_HEX;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SEND, ST_ECHO: begin
                    if (!reg_dat_wait) begin
                        reg_dat_we <= 1'b0;
                        state      <= (state == ST_ECHO) ? ST_DECODE : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Reply launch overrides the per-state next values above.
            if (rep_go) begin
                reg_dat_di <= {24'b0, rep_ack ? ACK_CHAR : NAK_CHAR};
                reg_dat_we <= 1'b1;
                cmd_err    <= !rep_ack;
                in_hex     <= 1'b0;
                state      <= ST_SEND;
                if (rep_ack) duty <= ack_duty;
            end
        end
    end

    rgb_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .hw_clk (hw_clk),
        .reset  (reset),
        .duty   (duty),
        .pwm    (pwm)
    );

    assign rgb_red   = pwm[0];
    assign rgb_green = pwm[1];
    assign rgb_blue  = pwm[2];

endmodule
